pingpong_bank_ctrl: RTL
=======================

// Module: pingpong_bank_ctrl
// PURPOSE
//  Sequences the two line-memory banks (A/B) between camera write side and VGA read side.
//  Sits in the CCLK domain between the camera input register stage and the dual-port line RAMs.
//  Generates the per-line write strobes and row address for the RAMs.
//  Swaps banks only when a complete camera frame is ready and the display has finished reading its bank.
//  Frames that arrive while a swap is pending are dropped, so a full bank is never overwritten.
// PARAMETERS
//  ADDR_WIDTH  10   width of oCL_ROW (RAM row address)
//  MAX_ROWS    480  rows accepted per frame; further lines are not written
//  CNT_WIDTH   8    width of oDROP_CNT
// PORTS
//  CLK          in   1           CCLK; single clock for the whole block
//  RST          in   1           asynchronous reset, active-high
//  iFVAL        in   1           frame valid (registered camera signal)
//  iLVAL        in   1           line valid (registered camera signal)
//  iRD_VSYNC    in   1           1-cycle pulse, display read side at vsync start, already synced to CLK
//  oWR_BANK     out  1           bank being written (0 = A, 1 = B)
//  oRD_BANK     out  1           bank being read; always ~oWR_BANK
//  oWEA         out  1           1-cycle write strobe, bank A
//  oWEB         out  1           1-cycle write strobe, bank B
//  oCL_ROW      out  ADDR_WIDTH  row address; valid in the cycle of oWEA or oWEB
//  oFRAME_DONE  out  1           1-cycle pulse when a written frame completes
//  oSWAP        out  1           1-cycle pulse in the cycle the banks swap
//  oOVERFLOW    out  1           sticky per frame; set when a line is seen beyond MAX_ROWS
//  oDROP_CNT    out  CNT_WIDTH   count of dropped frames; saturates at all-ones
// BEHAVIOUR
//  Reset values
//   - oWR_BANK=0, oRD_BANK=1, oCL_ROW=0, oDROP_CNT=0.
//   - All strobes/pulses 0; oOVERFLOW=0; state=IDLE.
//   - Reset mid-frame aborts the frame immediately; no strobe is emitted.
//  Edge detection
//   - iFVAL and iLVAL are registered once.
//   - rise/fall = current sample vs registered sample.
//  FSM
//   - IDLE: on FVAL rise -> WRITE; row counter := 0; oOVERFLOW := 0.
//   - WRITE, LVAL fall:
//     - if row < MAX_ROWS, pulse oWEA (oWR_BANK=0) or oWEB (oWR_BANK=1) with oCL_ROW=row, then row++.
//     - else set oOVERFLOW, no strobe.
//   - WRITE, FVAL fall:
//     - pulse oFRAME_DONE -> FULL.
//     - An LVAL fall in the same cycle is processed first; its strobe fires in that cycle.
//   - FULL:
//     - iRD_VSYNC -> swap, IDLE.
//     - FVAL rise -> DROP; oDROP_CNT++ (saturating).
//   - DROP:
//     - no strobes; row counter frozen.
//     - iRD_VSYNC -> swap, stay DROP.
//     - FVAL fall -> FULL if not swapped during this frame, else IDLE.
//     - FVAL fall and iRD_VSYNC in the same cycle: swap, go to IDLE.
//   - FULL, FVAL rise and iRD_VSYNC in the same cycle: swap, go to WRITE; frame not dropped.
//   - WRITE, FVAL fall and iRD_VSYNC in the same cycle: oFRAME_DONE and swap together, go to IDLE.
//  Swap
//   - oWR_BANK and oRD_BANK toggle one cycle after the swap cycle; oSWAP pulses in the swap cycle.
//   - Any write strobe emitted in the swap cycle uses the pre-swap bank.
//  Other rules
//   - iRD_VSYNC in IDLE or WRITE (not coincident with a frame end) is ignored.
//   - Latency: strobes and pulses are registered, asserted the cycle after the input edge is sampled.
//   - oWEA and oWEB are never high together.
//   - oCL_ROW holds its last value between strobes.
// TESTING
//  1. 4-line frame, then iRD_VSYNC -> WEA at rows 0,1,2,3; FRAME_DONE once; SWAP once; WR_BANK=1, RD_BANK=0.
//  2. Second frame arrives before iRD_VSYNC -> no WEA/WEB during it; DROP_CNT=1; after vsync + next frame, WEB rows 0..3.
//  3. MAX_ROWS=4, 6-line frame -> 4 strobes at rows 0..3; OVERFLOW=1; cleared at next FVAL rise.
//  4. iRD_VSYNC in the same cycle as FVAL fall (last LVAL fall coincident) -> last strobe at row 3, then FRAME_DONE+SWAP same cycle, IDLE.
//  5. RST pulse after row 2 -> outputs at reset values; next frame writes bank A from row 0.
//  6. 260 frames dropped with CNT_WIDTH=8 -> DROP_CNT saturates at 255; iRD_VSYNC in IDLE -> no SWAP.

Source files
------------

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong line bank sequencer: camera-side write strobes, row address,
// and frame-gated bank swaps against the display vsync.
module pingpong_bank_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_ROWS   = 480,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iFVAL,
  input  logic                  iLVAL,
  input  logic                  iRD_VSYNC,
  output logic                  oWR_BANK,
  output logic                  oRD_BANK,
  output logic                  oWEA,
  output logic                  oWEB,
  output logic [ADDR_WIDTH-1:0] oCL_ROW,
  output logic                  oFRAME_DONE,
  output logic                  oSWAP,
  output logic                  oOVERFLOW,
  output logic [CNT_WIDTH-1:0]  oDROP_CNT
);

  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam logic [RW-1:0] ROW_LIM = RW'(MAX_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL,
    DROP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic fval_q;
  logic lval_q;
  logic fval_rise;
  logic fval_fall;
  logic lval_fall;

  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic          swapped_q;
  logic          swapped_d;

  logic                  wr_bank_q;
  logic                  wea_q;
  logic                  wea_d;
  logic                  web_q;
  logic                  web_d;
  logic [ADDR_WIDTH-1:0] cl_row_q;
  logic [ADDR_WIDTH-1:0] cl_row_d;
  logic                  done_q;
  logic                  done_d;
  logic                  swap_q;
  logic                  swap_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic [CNT_WIDTH-1:0]  drop_q;
  logic [CNT_WIDTH-1:0]  drop_d;
  logic                  bank;

  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign lval_fall = ~iLVAL & lval_q;

  // Bank in effect when a strobe decided now reaches the RAM.
  assign bank = wr_bank_q ^ swap_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    swapped_d = swapped_q;
    wea_d     = 1'b0;
    web_d     = 1'b0;
    cl_row_d  = cl_row_q;
    done_d    = 1'b0;
    swap_d    = 1'b0;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    unique case (state_q)
      IDLE: begin
        if (fval_rise) begin
          state_d = WRITE;
          row_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      WRITE: begin
        if (lval_fall) begin
          if (row_q < ROW_LIM) begin
            wea_d    = ~bank;
            web_d    = bank;
            cl_row_d = ADDR_WIDTH'(row_q);
            row_d    = row_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (fval_fall) begin
          done_d = 1'b1;
          if (iRD_VSYNC) begin
            swap_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (iRD_VSYNC && fval_rise) begin
          swap_d  = 1'b1;
          state_d = WRITE;
          row_d   = '0;
          ovf_d   = 1'b0;
        end else if (iRD_VSYNC) begin
          swap_d  = 1'b1;
          state_d = IDLE;
        end else if (fval_rise) begin
          state_d   = DROP;
          swapped_d = 1'b0;
          if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
      end
      DROP: begin
        // Only one swap per full bank; afterwards nothing is pending.
        if (fval_fall) begin
          if (iRD_VSYNC && !swapped_q) begin
            swap_d  = 1'b1;
            state_d = IDLE;
          end else if (swapped_q) begin
            state_d = IDLE;
          end else begin
            state_d = FULL;
          end
        end else if (iRD_VSYNC && !swapped_q) begin
          swap_d    = 1'b1;
          swapped_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // Sampled edges start high so a frame in flight at reset is ignored.
      fval_q    <= 1'b1;
      lval_q    <= 1'b1;
      state_q   <= IDLE;
      row_q     <= '0;
      swapped_q <= 1'b0;
      wr_bank_q <= 1'b0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
      cl_row_q  <= '0;
      done_q    <= 1'b0;
      swap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      fval_q    <= iFVAL;
      lval_q    <= iLVAL;
      state_q   <= state_d;
      row_q     <= row_d;
      swapped_q <= swapped_d;
      wr_bank_q <= wr_bank_q ^ swap_q;
      wea_q     <= wea_d;
      web_q     <= web_d;
      cl_row_q  <= cl_row_d;
      done_q    <= done_d;
      swap_q    <= swap_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign oWR_BANK    = wr_bank_q;
  assign oRD_BANK    = ~wr_bank_q;
  assign oWEA        = wea_q;
  assign oWEB        = web_q;
  assign oCL_ROW     = cl_row_q;
  assign oFRAME_DONE = done_q;
  assign oSWAP       = swap_q;
  assign oOVERFLOW   = ovf_q;
  assign oDROP_CNT   = drop_q;

endmodule
